// File: rtl/reg_frame_rx.sv
// reg_frame_rx: receive side of the register-access link.
// Assembles fixed 4-byte frames {cmd, addr, wdata, crc} from a byte stream,
// checks CRC-8 (poly 0x2F, init 0xFF, MSB first, no final XOR) one byte per
// accepted beat, and presents good frames on a valid/ready handshake.
// Bad-CRC and timed-out frames are dropped and reported.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_vld/rx_data    incoming byte stream; rx_rdy high in IDLE/RECV
//   frm_vld/frm_rdy   decoded-frame handshake
//   frm_cmd/addr/wdata decoded frame fields, held after the handshake
//   crc_err, to_err   one-cycle drop pulses (CRC mismatch / inter-byte timeout)
//   err_cnt           saturating count of drop pulses
module reg_frame_rx #(
  parameter int unsigned TO_CYC = 255,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_vld,
  input  logic [7:0]       rx_data,
  output logic             rx_rdy,
  output logic             frm_vld,
  input  logic             frm_rdy,
  output logic [7:0]       frm_cmd,
  output logic [7:0]       frm_addr,
  output logic [7:0]       frm_wdata,
  output logic             crc_err,
  output logic             to_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0]       CRC_INIT = 8'hFF;
  localparam logic [7:0]       CRC_POLY = 8'h2F;
  localparam logic [15:0]      TO_LAST  = 16'(TO_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [7:0]       cmd_sh_q, cmd_sh_d;
  logic [7:0]       addr_sh_q, addr_sh_d;
  logic [7:0]       wdata_sh_q, wdata_sh_d;
  logic [7:0]       frm_cmd_q, frm_cmd_d;
  logic [7:0]       frm_addr_q, frm_addr_d;
  logic [7:0]       frm_wdata_q, frm_wdata_d;
  logic             frm_vld_q, frm_vld_d;
  logic             crc_err_q, crc_err_d;
  logic             to_err_q, to_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             rx_acc;
  logic [7:0]       residue;

  function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  assign rx_rdy    = (state_q != HOLD);
  assign rx_acc    = rx_vld & rx_rdy;
  assign residue   = crc_step(crc_q, rx_data);

  assign frm_vld   = frm_vld_q;
  assign frm_cmd   = frm_cmd_q;
  assign frm_addr  = frm_addr_q;
  assign frm_wdata = frm_wdata_q;
  assign crc_err   = crc_err_q;
  assign to_err    = to_err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    to_cnt_d    = to_cnt_q;
    cmd_sh_d    = cmd_sh_q;
    addr_sh_d   = addr_sh_q;
    wdata_sh_d  = wdata_sh_q;
    frm_cmd_d   = frm_cmd_q;
    frm_addr_d  = frm_addr_q;
    frm_wdata_d = frm_wdata_q;
    frm_vld_d   = frm_vld_q;
    crc_err_d   = 1'b0;
    to_err_d    = 1'b0;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rx_acc) begin
          cmd_sh_d   = rx_data;
          crc_d      = crc_step(CRC_INIT, rx_data);
          byte_cnt_d = 2'd1;
          to_cnt_d   = '0;
          state_d    = RECV;
        end
      end

      RECV: begin
        if (rx_acc) begin
          // An accept always clears the timeout, even on the cycle it would expire.
          to_cnt_d = '0;
          unique case (byte_cnt_q)
            2'd1: begin
              addr_sh_d  = rx_data;
              crc_d      = crc_step(crc_q, rx_data);
              byte_cnt_d = 2'd2;
            end
            2'd2: begin
              wdata_sh_d = rx_data;
              crc_d      = crc_step(crc_q, rx_data);
              byte_cnt_d = 2'd3;
            end
            default: begin
              if (residue == 8'h00) begin
                frm_cmd_d   = cmd_sh_q;
                frm_addr_d  = addr_sh_q;
                frm_wdata_d = wdata_sh_q;
                frm_vld_d   = 1'b1;
                state_d     = HOLD;
              end else begin
                crc_err_d = 1'b1;
                state_d   = IDLE;
              end
              crc_d      = CRC_INIT;
              byte_cnt_d = 2'd0;
            end
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          to_err_d   = 1'b1;
          state_d    = IDLE;
          crc_d      = CRC_INIT;
          byte_cnt_d = 2'd0;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      HOLD: begin
        if (frm_rdy) begin
          frm_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((crc_err_d || to_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      to_cnt_q    <= '0;
      cmd_sh_q    <= '0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      frm_cmd_q   <= '0;
      frm_addr_q  <= '0;
      frm_wdata_q <= '0;
      frm_vld_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      to_cnt_q    <= to_cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      addr_sh_q   <= addr_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_addr_q  <= frm_addr_d;
      frm_wdata_q <= frm_wdata_d;
      frm_vld_q   <= frm_vld_d;
      crc_err_q   <= crc_err_d;
      to_err_q    <= to_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_frame_rx.sv
module tb_reg_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_vld;
  logic       frm_rdy;
  logic [7:0] frm_cmd;
  logic [7:0] frm_addr;
  logic [7:0] frm_wdata;
  logic       crc_err;
  logic       to_err;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  reg_frame_rx #(.TO_CYC(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .rx_vld(rx_vld), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .frm_vld(frm_vld), .frm_rdy(frm_rdy),
    .frm_cmd(frm_cmd), .frm_addr(frm_addr), .frm_wdata(frm_wdata),
    .crc_err(crc_err), .to_err(to_err), .err_cnt(err_cnt)
  );

  // Bit-serial reference CRC-8 (poly 0x2F, MSB first).
  function automatic logic [7:0] model_crc(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h2F;
    end
    return c;
  endfunction

  function automatic logic [7:0] crc3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    return model_crc(model_crc(model_crc(8'hFF, a), b), d);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_vld = 1'b1;
    rx_data = b;
    while (rx_rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: rx_rdy=%b required 1", rx_rdy);
    end
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; frm_rdy = 1'b0;
    tick(); tick();
    n_cmp++;
    if (rx_rdy !== 1'b1 || frm_vld !== 1'b0 || crc_err !== 1'b0 || to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: rdy=%b vld=%b crc_err=%b to_err=%b required 1/0/0/0", rx_rdy, frm_vld, crc_err, to_err);
    end
    n_cmp++;
    if (frm_cmd !== 8'h00 || frm_addr !== 8'h00 || frm_wdata !== 8'h00 || err_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: cmd=%h addr=%h wdata=%h err_cnt=%h required 00", frm_cmd, frm_addr, frm_wdata, err_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_crc_ref;
    logic [7:0] r;
    r = model_crc(8'hFF, 8'h00);
    n_cmp++;
    if (r !== 8'h42) begin
      n_bad++;
      $display("FAIL crc_ref: model step(FF,00)=%h required 42", r);
    end
  endtask

  task automatic test_good_frame;
    frm_rdy = 1'b1;
    send_frame(8'h00, 8'h00, 8'h00, 8'h69);
    n_cmp++;
    if (frm_vld !== 1'b1 || rx_rdy !== 1'b0 || crc_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL good_ctrl: vld=%b rdy=%b crc_err=%b err_cnt=%0d required 1/0/0/0", frm_vld, rx_rdy, crc_err, err_cnt);
    end
    n_cmp++;
    if (frm_cmd !== 8'h00 || frm_addr !== 8'h00 || frm_wdata !== 8'h00) begin
      n_bad++;
      $display("FAIL good_data: %h/%h/%h required 00/00/00", frm_cmd, frm_addr, frm_wdata);
    end
    tick();
    n_cmp++;
    if (frm_vld !== 1'b0 || rx_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL good_release: vld=%b rdy=%b required 0/1", frm_vld, rx_rdy);
    end
    frm_rdy = 1'b0;
  endtask

  task automatic test_bad_crc;
    frm_rdy = 1'b1;
    send_frame(8'h00, 8'h00, 8'h00, 8'h68);
    exp_err++;
    n_cmp++;
    if (frm_vld !== 1'b0 || crc_err !== 1'b1 || to_err !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL bad_crc: vld=%b crc_err=%b to_err=%b err_cnt=%0d required 0/1/0/%0d", frm_vld, crc_err, to_err, err_cnt, exp_err);
    end
    tick();
    n_cmp++;
    if (crc_err !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL bad_crc_pulse: crc_err=%b err_cnt=%0d required 0/%0d", crc_err, err_cnt, exp_err);
    end
    send_frame(8'h00, 8'h00, 8'h00, 8'h69);
    n_cmp++;
    if (frm_vld !== 1'b1 || crc_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_crc_recover: vld=%b crc_err=%b required 1/0", frm_vld, crc_err);
    end
    tick();
    frm_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0] c;
    c = crc3(8'hA5, 8'h3C, 8'hC3);
    frm_rdy = 1'b0;
    send_frame(8'hA5, 8'h3C, 8'hC3, c);
    n_cmp++;
    if (frm_vld !== 1'b1 || frm_cmd !== 8'hA5 || frm_addr !== 8'h3C || frm_wdata !== 8'hC3) begin
      n_bad++;
      $display("FAIL bp_frame: vld=%b %h/%h/%h required 1 a5/3c/c3", frm_vld, frm_cmd, frm_addr, frm_wdata);
    end
    // A byte offered during HOLD must be ignored.
    rx_vld = 1'b1;
    rx_data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (frm_vld !== 1'b1 || rx_rdy !== 1'b0 || frm_cmd !== 8'hA5 || frm_addr !== 8'h3C || frm_wdata !== 8'hC3) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b %h/%h/%h required 1/0 a5/3c/c3", i, frm_vld, rx_rdy, frm_cmd, frm_addr, frm_wdata);
      end
    end
    rx_vld = 1'b0;
    frm_rdy = 1'b1;
    tick();
    frm_rdy = 1'b0;
    n_cmp++;
    if (frm_vld !== 1'b0 || rx_rdy !== 1'b1 || frm_cmd !== 8'hA5 || frm_wdata !== 8'hC3) begin
      n_bad++;
      $display("FAIL bp_release: vld=%b rdy=%b cmd=%h wdata=%h required 0/1 a5 c3", frm_vld, rx_rdy, frm_cmd, frm_wdata);
    end
    tick(); tick();
    n_cmp++;
    if (frm_vld !== 1'b0 || crc_err !== 1'b0 || rx_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ignored_byte: vld=%b crc_err=%b rdy=%b required 0/0/1", frm_vld, crc_err, rx_rdy);
    end
  endtask

  task automatic test_timeout;
    send_byte(8'h00);
    send_byte(8'h00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (to_err !== 1'b0 || rx_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL to_early[%0d]: to_err=%b rdy=%b required 0/1", k, to_err, rx_rdy);
      end
    end
    tick();
    exp_err++;
    n_cmp++;
    if (to_err !== 1'b1 || crc_err !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL to_pulse: to_err=%b crc_err=%b err_cnt=%0d required 1/0/%0d", to_err, crc_err, err_cnt, exp_err);
    end
    tick();
    n_cmp++;
    if (to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pulse_width: to_err=%b required 0", to_err);
    end
    frm_rdy = 1'b1;
    send_frame(8'h00, 8'h00, 8'h00, 8'h69);
    n_cmp++;
    if (frm_vld !== 1'b1 || frm_cmd !== 8'h00 || crc_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_recover: vld=%b cmd=%h crc_err=%b required 1/00/0", frm_vld, frm_cmd, crc_err);
    end
    tick();
    frm_rdy = 1'b0;
  endtask

  task automatic test_timeout_boundary;
    logic [7:0] c;
    c = crc3(8'h11, 8'h22, 8'h33);
    send_byte(8'h11);
    repeat (7) tick();
    send_byte(8'h22);
    n_cmp++;
    if (to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_edge_1: to_err=%b required 0", to_err);
    end
    repeat (7) tick();
    send_byte(8'h33);
    n_cmp++;
    if (to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_edge_2: to_err=%b required 0", to_err);
    end
    send_byte(c);
    n_cmp++;
    if (frm_vld !== 1'b1 || frm_cmd !== 8'h11 || frm_addr !== 8'h22 || frm_wdata !== 8'h33 || to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_edge_frame: vld=%b %h/%h/%h to_err=%b required 1 11/22/33 0", frm_vld, frm_cmd, frm_addr, frm_wdata, to_err);
    end
    frm_rdy = 1'b1;
    tick();
    frm_rdy = 1'b0;
  endtask

  task automatic test_random_frames;
    logic [7:0] b [4];
    logic [7:0] g [3];
    logic bad;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < 3; j++) begin
        b[j] = 8'($urandom);
        g[j] = b[j];
      end
      b[3] = crc3(b[0], b[1], b[2]);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) b[$urandom_range(0, 3)] ^= 8'($urandom_range(1, 255));
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 3)) tick();
        send_byte(b[j]);
      end
      n_cmp++;
      if (bad) begin
        exp_err++;
        if (frm_vld !== 1'b0 || crc_err !== 1'b1 || err_cnt !== 8'(exp_err)) begin
          n_bad++;
          $display("FAIL rand_bad[%0d]: vld=%b crc_err=%b err_cnt=%0d required 0/1/%0d", f, frm_vld, crc_err, err_cnt, exp_err);
        end
        tick();
      end else begin
        if (frm_vld !== 1'b1 || crc_err !== 1'b0 || frm_cmd !== g[0] || frm_addr !== g[1] || frm_wdata !== g[2]) begin
          n_bad++;
          $display("FAIL rand_good[%0d]: vld=%b crc_err=%b %h/%h/%h required 1/0 %h/%h/%h", f, frm_vld, crc_err, frm_cmd, frm_addr, frm_wdata, g[0], g[1], g[2]);
        end
        repeat ($urandom_range(0, 4)) tick();
        frm_rdy = 1'b1;
        tick();
        frm_rdy = 1'b0;
        n_cmp++;
        if (frm_vld !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_release[%0d]: vld=%b required 0", f, frm_vld);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    send_byte(8'h00);
    send_byte(8'h00);
    #2 rst = 1'b1;
    #1;
    exp_err = 0;
    n_cmp++;
    if (rx_rdy !== 1'b1 || frm_vld !== 1'b0 || err_cnt !== 8'd0 || crc_err !== 1'b0 || to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_recv: rdy=%b vld=%b err_cnt=%0d crc_err=%b to_err=%b required 1/0/0/0/0", rx_rdy, frm_vld, err_cnt, crc_err, to_err);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (to_err !== 1'b0 || crc_err !== 1'b0) begin
        n_bad++;
        $display("FAIL arst_no_pulse[%0d]: to_err=%b crc_err=%b required 0/0", i, to_err, crc_err);
      end
    end
    frm_rdy = 1'b0;
    send_frame(8'h5A, 8'h6B, 8'h7C, crc3(8'h5A, 8'h6B, 8'h7C));
    n_cmp++;
    if (frm_vld !== 1'b1 || frm_cmd !== 8'h5A) begin
      n_bad++;
      $display("FAIL arst_pre_hold: vld=%b cmd=%h required 1/5a", frm_vld, frm_cmd);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (frm_vld !== 1'b0 || rx_rdy !== 1'b1 || frm_cmd !== 8'h00 || frm_addr !== 8'h00 || frm_wdata !== 8'h00 || err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL arst_hold: vld=%b rdy=%b %h/%h/%h err_cnt=%0d required 0/1 00/00/00 0", frm_vld, rx_rdy, frm_cmd, frm_addr, frm_wdata, err_cnt);
    end
    #2 rst = 1'b0;
    tick();
    n_cmp++;
    if (crc_err !== 1'b0 || to_err !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_hold_pulse: crc_err=%b to_err=%b required 0/0", crc_err, to_err);
    end
    frm_rdy = 1'b1;
    send_frame(8'h00, 8'h00, 8'h00, 8'h69);
    n_cmp++;
    if (frm_vld !== 1'b1 || crc_err !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_recover: vld=%b crc_err=%b required 1/0", frm_vld, crc_err);
    end
    tick();
    frm_rdy = 1'b0;
  endtask

  task automatic test_saturation;
    frm_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h00, 8'h00, 8'h00, 8'h68);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      n_cmp++;
      if (crc_err !== 1'b1 || err_cnt !== 8'(exp_err)) begin
        n_bad++;
        $display("FAIL sat[%0d]: crc_err=%b err_cnt=%0d required 1/%0d", f, crc_err, err_cnt, exp_err);
      end
    end
    tick();
    n_cmp++;
    if (err_cnt !== 8'hFF) begin
      n_bad++;
      $display("FAIL sat_final: err_cnt=%h required ff", err_cnt);
    end
    frm_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_crc_ref();
    test_good_frame();
    test_bad_crc();
    test_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_random_frames();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_frame_rx.md
Name: reg_frame_rx

Overview:
- Receive side of the register-access link. Takes a byte stream of fixed 4-byte frames {cmd, addr, wdata, crc} and checks the CRC-8 byte-serially with one LFSR step per accepted byte.
- Presents each good frame to the register file over a valid/ready handshake.
- Drops bad or stalled frames and reports them with error pulses and a saturating error counter.

Parameters:
- TO_CYC, 255: inter-byte timeout in clk cycles while a frame is partially received (1..65535).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_vld  in  1  rx_data valid
- rx_data  in  8  incoming byte
- rx_rdy  out  1  block can accept a byte; a byte transfers when rx_vld & rx_rdy
- frm_vld  out  1  decoded frame valid
- frm_rdy  in  1  downstream accepts the frame; transfer when frm_vld & frm_rdy
- frm_cmd  out  8  byte 0 of frame
- frm_addr  out  8  byte 1 of frame
- frm_wdata  out  8  byte 2 of frame
- crc_err  out  1  one-cycle pulse: frame dropped, CRC mismatch
- to_err  out  1  one-cycle pulse: frame dropped, timeout
- err_cnt  out  ERR_W  count of crc_err + to_err events, saturates at all-ones

Behaviour:
- CRC: poly x^8+x^5+x^3+x^2+x+1 (0x2F), non-reflected, MSB first, init 0xFF, no final XOR.
  - Per byte: c = c ^ byte, then 8 times: c = c[7] ? ((c<<1)^0x2F) : (c<<1), truncated to 8 bits.
  - Must match the team's CRC-8 generator bit-for-bit.
  - Check: after all 4 bytes are folded in, the residue is 0x00 for a good frame.
- Reset: state IDLE, byte_cnt=0, crc=0xFF, frm_vld=0, frm_cmd/addr/wdata=0x00, crc_err=0, to_err=0, err_cnt=0, timeout counter=0.
- States: IDLE, RECV, HOLD.
- rx_rdy = 1 in IDLE and RECV, 0 in HOLD (combinational from state).
- IDLE:
  - On a byte accept: byte 0 goes to a cmd shadow register; crc = step(0xFF, byte); byte_cnt=1; go to RECV.
- RECV:
  - byte_cnt 1 and 2: store the byte to the addr/wdata shadow, step the CRC, increment byte_cnt, clear the timeout counter.
  - byte_cnt 3 (CRC byte): compute residue = step(crc, byte).
    - Residue 0x00: next cycle, copy the shadows to the frm_* outputs, frm_vld=1, go to HOLD.
    - Otherwise: crc_err pulse next cycle, go to IDLE.
  - Either way, crc reloads 0xFF and byte_cnt is cleared.
  - Timeout counter increments every RECV cycle with no accept.
    - When it reaches TO_CYC: to_err pulse, state goes to IDLE, crc reloads 0xFF, byte_cnt=0, counter clears.
    - An accept in the same cycle as the counter reaching TO_CYC wins; no timeout.
- HOLD:
  - frm_* outputs are stable while frm_vld=1.
  - On frm_vld & frm_rdy: frm_vld=0 next cycle, go to IDLE. rx_rdy returns high that same next cycle.
  - No timeout in HOLD.
- Latency: CRC byte accepted in cycle N gives frm_vld or crc_err in cycle N+1. Back-to-back frames have a minimum 1 idle rx_rdy cycle (the HOLD cycle) if frm_rdy is tied high.
- err_cnt: +1 per crc_err or to_err pulse. The two cannot coincide. Holds at 2^ERR_W-1.
- frm_* outputs keep their last values after the handshake; only frm_vld clears.
- rx_vld with rx_rdy=0 has no effect; the sender must hold the byte.
- Reset mid-frame or in HOLD: immediately return to reset values, partial frame discarded, no error pulse.

Test Plan:
- Good frame, zero payload: bytes 00,00,00,69, frm_rdy=1 -> frm_vld=1 one cycle after the 4th accept; cmd/addr/wdata=00/00/00; crc_err=0; err_cnt=0.
- Bad CRC: bytes 00,00,00,68 -> no frm_vld; crc_err pulses 1 cycle; err_cnt=1; next good frame 00,00,00,69 is accepted normally.
- Backpressure: good frame with frm_rdy=0 for 10 cycles -> frm_vld held, outputs stable, rx_rdy=0 for those cycles; frm_rdy=1 -> frm_vld=0 and rx_rdy=1 the following cycle.
- Timeout with TO_CYC=8: send 00,00 then idle -> to_err pulses after exactly 8 idle cycles; err_cnt increments; following frame 00,00,00,69 is decoded correctly.
- Random frames vs golden CRC-8 model (poly 0x2F, init 0xFF), including a single-byte reference check step(0xFF,0x00)=0x42; random rx_vld/frm_rdy gaps -> every good frame delivered in order, every corrupted frame flagged; err_cnt saturates at 0xFF after 300 bad frames.
- Async rst asserted mid-RECV and in HOLD -> all outputs return to reset values at once; no crc_err or to_err pulse.
